druaga_spram: RTL and testbench

CPU-side sprite attribute RAM for the Druaga/Mappy-family video core: the writer end of the 24-bit sprite-attribute read interface consumed by the sprite line renderer. Decodes the CPU's three 128-byte sprite banks (0x0F80, 0x1780, 0x1F80), services CPU byte reads/writes, and presents all three banks as one 24-bit word per sprite-register address. An optional vertical-blank snapshot engine copies the live RAM into a display shadow so the renderer sees a frame-coherent sprite list.

---
 rtl/druaga_spram.sv | 151 +++++++++++++++
 tb/tb_druaga_spram.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/druaga_spram.sv
// CPU-side sprite attribute RAM: three 128-byte banks presented to the renderer as one 24-bit word.
// Define SPRAM_SNAPSHOT_EN to add the vertical-blank shadow copy engine.
module druaga_spram (
  input  logic        VCLKx8,
  input  logic        RESET,
  input  logic [15:0] CPU_AD,
  input  logic        CPU_WE,
  input  logic [7:0]  CPU_DO,
  output logic [7:0]  CPU_DI,
  output logic        CPU_HIT,
  input  logic        VBLK,
  input  logic [6:0]  SPRA_A,
  output logic [23:0] SPRA_D,
  output logic        COPY_BUSY
);

  localparam int DATA_W = 8;
  localparam int DEPTH  = 128;

  logic [DATA_W-1:0] live0 [DEPTH];
  logic [DATA_W-1:0] live1 [DEPTH];
  logic [DATA_W-1:0] live2 [DEPTH];

  logic [1:0] bsel;
  logic [6:0] idx;
  logic       wr0, wr1, wr2;

  // Bank field 01/10/11 selects bank 0/1/2; 00 is outside the sprite area.
  assign bsel    = CPU_AD[12:11];
  assign idx     = CPU_AD[6:0];
  assign CPU_HIT = (CPU_AD[15:13] == 3'd0) && (CPU_AD[10:7] == 4'hF) && (bsel != 2'd0);
  assign wr0     = CPU_WE && CPU_HIT && (bsel == 2'd1);
  assign wr1     = CPU_WE && CPU_HIT && (bsel == 2'd2);
  assign wr2     = CPU_WE && CPU_HIT && (bsel == 2'd3);

  always_ff @(posedge VCLKx8) begin
    if (wr0) live0[idx] <= CPU_DO;
    if (wr1) live1[idx] <= CPU_DO;
    if (wr2) live2[idx] <= CPU_DO;
  end

  always_ff @(posedge VCLKx8) begin
    if (RESET) begin
      CPU_DI <= '0;
    end else if (CPU_HIT) begin
      case (bsel)
        2'd1:    CPU_DI <= live0[idx];
        2'd2:    CPU_DI <= live1[idx];
        default: CPU_DI <= live2[idx];
      endcase
    end
  end

`ifdef SPRAM_SNAPSHOT_EN
  typedef enum logic {IDLE, COPY} state_t;

  logic [DATA_W-1:0] sh0 [DEPTH];
  logic [DATA_W-1:0] sh1 [DEPTH];
  logic [DATA_W-1:0] sh2 [DEPTH];

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              vblk_dly_q, vblk_dly_d;
  logic              rd_en;
  logic              vld_p0;
  logic [6:0]        idx_p0;
  logic [DATA_W-1:0] cp0_p0, cp1_p0, cp2_p0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    vblk_dly_d = vblk_dly_q;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        vblk_dly_d = VBLK;
        if (VBLK && !vblk_dly_q) begin
          state_d = COPY;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      COPY: begin
        // cnt 0..127 read one entry each; cnt 128 only drains the last write.
        if (cnt_q == 8'd128) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          rd_en = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge VCLKx8) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      vblk_dly_q <= 1'b1;
      vld_p0     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      vblk_dly_q <= vblk_dly_d;
      vld_p0     <= rd_en;
    end
  end

  // p0: live read of entry cnt; shadow write of that entry one cycle later
  always_ff @(posedge VCLKx8) begin
    if (rd_en) begin
      cp0_p0 <= live0[cnt_q[6:0]];
      cp1_p0 <= live1[cnt_q[6:0]];
      cp2_p0 <= live2[cnt_q[6:0]];
      idx_p0 <= cnt_q[6:0];
    end
    // A reset aborts the pending write too, leaving the shadow partially copied.
    if (vld_p0 && !RESET) begin
      sh0[idx_p0] <= cp0_p0;
      sh1[idx_p0] <= cp1_p0;
      sh2[idx_p0] <= cp2_p0;
    end
  end

  always_ff @(posedge VCLKx8) begin
    if (RESET) SPRA_D <= '0;
    else       SPRA_D <= {sh2[SPRA_A], sh1[SPRA_A], sh0[SPRA_A]};
  end

  assign COPY_BUSY = busy_q;
`else
  logic unused_vblk;
  assign unused_vblk = VBLK;

  // Renderer sees live RAM directly, tearing included.
  always_ff @(posedge VCLKx8) begin
    if (RESET) SPRA_D <= '0;
    else       SPRA_D <= {live2[SPRA_A], live1[SPRA_A], live0[SPRA_A]};
  end

  assign COPY_BUSY = 1'b0;
`endif

endmodule

// File: tb/tb_druaga_spram.sv
// Bench for druaga_spram: decode table, randomized CPU/renderer traffic against an array model,
// and snapshot-engine corner sequences when SPRAM_SNAPSHOT_EN is defined.
module tb_druaga_spram;

  logic        clk = 1'b0;
  logic        RESET, CPU_WE, CPU_HIT, VBLK, COPY_BUSY;
  logic [15:0] CPU_AD;
  logic [7:0]  CPU_DO, CPU_DI;
  logic [6:0]  SPRA_A;
  logic [23:0] SPRA_D;

  always #5 clk = ~clk;

  druaga_spram dut (
    .VCLKx8(clk), .RESET(RESET), .CPU_AD(CPU_AD), .CPU_WE(CPU_WE), .CPU_DO(CPU_DO),
    .CPU_DI(CPU_DI), .CPU_HIT(CPU_HIT), .VBLK(VBLK), .SPRA_A(SPRA_A), .SPRA_D(SPRA_D),
    .COPY_BUSY(COPY_BUSY)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] m_live   [3][128];
  logic [7:0] m_shadow [3][128];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wd;
    bit          hit;
    logic [7:0]  rd;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sprite banks are the three 128-byte windows at 0x0F80, 0x1780, 0x1F80.
  function automatic bit m_hit(input logic [15:0] a);
    int ai = int'(a);
    return (ai >= 'h0F80 && ai < 'h1000) || (ai >= 'h1780 && ai < 'h1800) ||
           (ai >= 'h1F80 && ai < 'h2000);
  endfunction

  function automatic int m_bank(input logic [15:0] a);
    return (int'(a) - 'h0F80) / 'h800;
  endfunction

  function automatic int m_idx(input logic [15:0] a);
    return int'(a) - 'h0F80 - m_bank(a) * 'h800;
  endfunction

  function automatic logic [15:0] bank_addr(input int b, input int i);
    return 16'('h0F80 + b * 'h800 + i);
  endfunction

  function automatic logic [23:0] live_word(input int a);
    return {m_live[2][a], m_live[1][a], m_live[0][a]};
  endfunction

  function automatic logic [23:0] shadow_word(input int a);
    return {m_shadow[2][a], m_shadow[1][a], m_shadow[0][a]};
  endfunction

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    CPU_AD = a;
    CPU_DO = d;
    CPU_WE = 1'b1;
    if (m_hit(a)) m_live[m_bank(a)][m_idx(a)] = d;
    tick;
    CPU_WE = 1'b0;
  endtask

  task automatic check_live_all;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 128; i++) begin
        CPU_AD = bank_addr(b, i);
        tick;
        chk($sformatf("live_b%0d_i%0d", b, i), CPU_DI, m_live[b][i]);
      end
  endtask

  task automatic check_shadow_all;
    for (int a = 0; a < 128; a++) begin
      SPRA_A = 7'(a);
      tick;
      chk($sformatf("spra_%0d", a), SPRA_D, shadow_word(a));
    end
  endtask

  // Full VBLK-triggered copy; optional writes to bank0 entries 0 and 127 while it runs.
  // An entry takes the live value present when the read pointer passes it.
  task automatic run_copy(input bit do_wr, input logic [7:0] v0, input logic [7:0] v127);
    int n;
    VBLK = 1'b0;
    tick;
    VBLK = 1'b1;
    m_shadow = m_live;
    tick;
    chk("busy_rise", COPY_BUSY, 1);
    n = 1;
    while (n < 300) begin
      CPU_WE = 1'b0;
      // Next edge is copy cycle n-1, reading entry n-1.
      if (do_wr && n == 5) begin
        CPU_AD = bank_addr(0, 0); CPU_DO = v0; CPU_WE = 1'b1;
        m_live[0][0] = v0;
        if (0 > n - 1) m_shadow[0][0] = v0;
      end
      if (do_wr && n == 6) begin
        CPU_AD = bank_addr(0, 127); CPU_DO = v127; CPU_WE = 1'b1;
        m_live[0][127] = v127;
        if (127 > n - 1) m_shadow[0][127] = v127;
      end
      tick;
      if (!COPY_BUSY) break;
      n++;
    end
    CPU_WE = 1'b0;
    VBLK = 1'b0;
    chk("busy_len", n, 129);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d, exp_di;
    logic [23:0] exp_sp, old_w;
    logic [6:0]  sa;
    bit          we;
    int          r;

    tv[0] = '{16'h0F80, 8'h11, 1'b1, 8'h11};
    tv[1] = '{16'h1780, 8'h22, 1'b1, 8'h22};
    tv[2] = '{16'h1F80, 8'h33, 1'b1, 8'h33};
    tv[3] = '{16'h0780, 8'h44, 1'b0, 8'h33};
    tv[4] = '{16'h2F80, 8'h55, 1'b0, 8'h33};
    tv[5] = '{16'h0FFF, 8'h66, 1'b1, 8'h66};
    tv[6] = '{16'h8F80, 8'h77, 1'b0, 8'h66};
    tv[7] = '{16'h0F7F, 8'h88, 1'b0, 8'h66};

    RESET = 1'b1; CPU_WE = 1'b0; CPU_AD = '0; CPU_DO = '0; VBLK = 1'b0; SPRA_A = '0;
    tick;
    tick;
    chk("rst_cpu_di", CPU_DI, 0);
    chk("rst_spra_d", SPRA_D, 0);
    chk("rst_busy", COPY_BUSY, 0);
    RESET = 1'b0;

    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 128; i++) cpu_write(bank_addr(b, i), 8'($urandom));

`ifdef SPRAM_SNAPSHOT_EN
    run_copy(1'b0, 8'h00, 8'h00);
`endif

    // Decode table: write each vector, then read them back in order.
    foreach (tv[i]) begin
      CPU_AD = tv[i].addr; CPU_DO = tv[i].wd; CPU_WE = 1'b1;
      #1;
      chk($sformatf("hit_%0h", tv[i].addr), CPU_HIT, tv[i].hit);
      if (m_hit(tv[i].addr)) m_live[m_bank(tv[i].addr)][m_idx(tv[i].addr)] = tv[i].wd;
      tick;
      CPU_WE = 1'b0;
    end
    foreach (tv[i]) begin
      CPU_AD = tv[i].addr;
      tick;
      chk($sformatf("rd_%0h", tv[i].addr), CPU_DI, tv[i].rd);
    end
    check_live_all;

    CPU_AD = 16'h0F80;
    tick;
    exp_di = m_live[0][0];
    chk("rand_sync", CPU_DI, exp_di);
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 3);
      a  = (r < 3) ? bank_addr(r, $urandom_range(0, 127)) : 16'($urandom);
      we = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      sa = 7'($urandom_range(0, 127));
      CPU_AD = a; CPU_WE = we; CPU_DO = d; SPRA_A = sa;
      #1;
      chk($sformatf("rhit_%0d", k), CPU_HIT, m_hit(a));
      if (m_hit(a)) exp_di = m_live[m_bank(a)][m_idx(a)];
`ifdef SPRAM_SNAPSHOT_EN
      exp_sp = shadow_word(sa);
`else
      exp_sp = live_word(sa);
`endif
      if (we && m_hit(a)) m_live[m_bank(a)][m_idx(a)] = d;
      tick;
      chk($sformatf("rdi_%0d", k), CPU_DI, exp_di);
      chk($sformatf("rspra_%0d", k), SPRA_D, exp_sp);
    end
    CPU_WE = 1'b0;

`ifdef SPRAM_SNAPSHOT_EN
    cpu_write(bank_addr(0, 5), 8'h11);
    cpu_write(bank_addr(1, 5), 8'h22);
    cpu_write(bank_addr(2, 5), 8'h33);
    SPRA_A = 7'd5;
    tick;
    chk("spra5_old", SPRA_D, shadow_word(5));
    run_copy(1'b0, 8'h00, 8'h00);
    tick;
    chk("spra5_new", SPRA_D, 24'h332211);

    run_copy(1'b1, ~m_live[0][0], ~m_live[0][127]);
    check_shadow_all;

    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 128; i++)
        cpu_write(bank_addr(b, i), m_live[b][i] ^ 8'($urandom_range(1, 255)));
    VBLK = 1'b0;
    tick;
    VBLK = 1'b1;
    tick;
    chk("rst_copy_rise", COPY_BUSY, 1);
    for (int k = 0; k < 60; k++) tick;
    RESET = 1'b1;
    tick;
    chk("rst_copy_abort", COPY_BUSY, 0);
    RESET = 1'b0;
    for (int i = 0; i < 59; i++)
      for (int b = 0; b < 3; b++) m_shadow[b][i] = m_live[b][i];
    for (int k = 0; k < 5; k++) begin
      tick;
      chk($sformatf("no_copy_after_rst_%0d", k), COPY_BUSY, 0);
    end
    VBLK = 1'b0;
    check_shadow_all;
`else
    SPRA_A = 7'd9;
    old_w = live_word(9);
    cpu_write(bank_addr(0, 9), ~m_live[0][9]);
    cpu_write(bank_addr(1, 9), ~m_live[1][9]);
    cpu_write(bank_addr(2, 9), ~m_live[2][9]);
    chk("spra9_rbw", SPRA_D, {old_w[23:16], m_live[1][9], m_live[0][9]});
    tick;
    chk("spra9_new", SPRA_D, live_word(9));
    VBLK = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("busy_tied_%0d", k), COPY_BUSY, 0);
    end
    VBLK = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
